// File: rtl/struct_assign.sv
// struct_assign: joins a struct stream with a field-value stream, overwrites
// the field [ASSIGN_OFFSET +: ASSIGN_SIZE] of each struct with the paired value,
// and emits the result through a two-entry skid buffer (OUT + TMP) so that no
// output depends combinationally on m_struct_axis_tready.
module struct_assign #(
  parameter int STRUCT_WIDTH  = 16,
  parameter int ASSIGN_OFFSET = 0,
  parameter int ASSIGN_SIZE   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STRUCT_WIDTH-1:0] s_struct_axis_tdata,
  input  logic                    s_struct_axis_tvalid,
  output logic                    s_struct_axis_tready,
  input  logic [ASSIGN_SIZE-1:0]  s_val_axis_tdata,
  input  logic                    s_val_axis_tvalid,
  output logic                    s_val_axis_tready,
  output logic [STRUCT_WIDTH-1:0] m_struct_axis_tdata,
  output logic                    m_struct_axis_tvalid,
  input  logic                    m_struct_axis_tready
);

  // A field that is empty or spills past the struct cannot be built.
  generate
    if (ASSIGN_SIZE == 0 || ASSIGN_OFFSET + ASSIGN_SIZE > STRUCT_WIDTH) begin : g_bad_params
      $error("struct_assign: field [ASSIGN_OFFSET +: ASSIGN_SIZE] does not fit in STRUCT_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // OUT and TMP invalid
    ST_ONE   = 2'd1,  // OUT valid
    ST_FULL  = 2'd2   // OUT and TMP valid
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic                    in_rdy_reg;
  logic [STRUCT_WIDTH-1:0] out_reg;
  logic [STRUCT_WIDTH-1:0] tmp_reg;
  logic [STRUCT_WIDTH-1:0] joined;
  logic                    join_fire;
  logic                    out_fire;
  logic                    load_out_in;
  logic                    load_out_tmp;
  logic                    load_tmp;

  // Build the joined word bit by bit: field bits come from the value stream,
  // every other bit passes through from the struct stream.
  genvar gi;
  generate
    for (gi = 0; gi < STRUCT_WIDTH; gi++) begin : g_join_bits
      if (gi >= ASSIGN_OFFSET && gi < ASSIGN_OFFSET + ASSIGN_SIZE) begin : g_field
        assign joined[gi] = s_val_axis_tdata[gi-ASSIGN_OFFSET];
      end else begin : g_keep
        assign joined[gi] = s_struct_axis_tdata[gi];
      end
    end
  endgenerate

  // Each input is only ready when its partner is valid, so the pair moves together.
  assign s_struct_axis_tready = in_rdy_reg & s_val_axis_tvalid;
  assign s_val_axis_tready    = in_rdy_reg & s_struct_axis_tvalid;
  assign join_fire            = in_rdy_reg & s_struct_axis_tvalid & s_val_axis_tvalid;

  assign m_struct_axis_tvalid = (state_reg != ST_EMPTY);
  assign m_struct_axis_tdata  = out_reg;
  assign out_fire             = m_struct_axis_tvalid & m_struct_axis_tready;

  // Next-state and register-load decisions for the skid buffer.
  always_comb begin
    state_next   = state_reg;
    load_out_in  = 1'b0;
    load_out_tmp = 1'b0;
    load_tmp     = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (join_fire) begin
          state_next  = ST_ONE;
          load_out_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (join_fire && !out_fire) begin
          state_next = ST_FULL;
          load_tmp   = 1'b1;
        end else if (join_fire && out_fire) begin
          load_out_in = 1'b1;
        end else if (out_fire) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_rdy is low here, so no join can arrive; only the drain matters.
        if (out_fire) begin
          state_next   = ST_ONE;
          load_out_tmp = 1'b1;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
  end

  // Control state; in_rdy is precomputed so it is low exactly while TMP holds a word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_EMPTY;
      in_rdy_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      in_rdy_reg <= (state_next != ST_FULL);
    end
  end

  // Data registers carry no reset; their contents are ignored while invalid.
  always_ff @(posedge clk) begin
    if (load_out_in) begin
      out_reg <= joined;
    end else if (load_out_tmp) begin
      out_reg <= tmp_reg;
    end
    if (load_tmp) begin
      tmp_reg <= joined;
    end
  end

endmodule

// File: tb/tb_struct_assign.sv
// Testbench for struct_assign (16-bit struct, 4-bit field at bit 4).
// Inputs change 1 time unit after the rising edge; the monitor samples on the
// falling edge, where handshake signals equal what the next rising edge sees.
module tb_struct_assign;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] s_struct_axis_tdata = '0;
  logic        s_struct_axis_tvalid = 1'b0;
  logic        s_struct_axis_tready;
  logic [3:0]  s_val_axis_tdata = '0;
  logic        s_val_axis_tvalid = 1'b0;
  logic        s_val_axis_tready;
  logic [15:0] m_struct_axis_tdata;
  logic        m_struct_axis_tvalid;
  logic        m_struct_axis_tready = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          n_out = 0;
  logic        verbose = 1'b1;
  logic [15:0] sb[$];
  logic        hold_prev = 1'b0;
  logic [15:0] prev_data = '0;

  struct_assign #(
    .STRUCT_WIDTH (16),
    .ASSIGN_OFFSET(4),
    .ASSIGN_SIZE  (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_struct_axis_tdata (s_struct_axis_tdata),
    .s_struct_axis_tvalid(s_struct_axis_tvalid),
    .s_struct_axis_tready(s_struct_axis_tready),
    .s_val_axis_tdata    (s_val_axis_tdata),
    .s_val_axis_tvalid   (s_val_axis_tvalid),
    .s_val_axis_tready   (s_val_axis_tready),
    .m_struct_axis_tdata (m_struct_axis_tdata),
    .m_struct_axis_tvalid(m_struct_axis_tvalid),
    .m_struct_axis_tready(m_struct_axis_tready)
  );

  always #5 clk = ~clk;

  // Expected word: bits [7:4] of the struct replaced by the value.
  function automatic logic [15:0] model(input logic [15:0] s, input logic [3:0] v);
    logic [15:0] r;
    r = s;
    r[7:4] = v;
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pop/compare on output handshakes, push on joins,
  // and require the output to stay frozen while stalled.
  always @(negedge clk) begin
    logic [15:0] exp_word;
    if (rst) begin
      if (hold_prev) begin
        checks++;
        if (m_struct_axis_tvalid !== 1'b1 || m_struct_axis_tdata !== prev_data) begin
          errors++;
          $display("FAIL hold_stable: tvalid=%b tdata=%h, required tvalid=1 tdata=%h",
                   m_struct_axis_tvalid, m_struct_axis_tdata, prev_data);
        end
      end
      if (m_struct_axis_tvalid && m_struct_axis_tready) begin
        checks++;
        n_out++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_order: got tdata=%h, required no output (scoreboard empty)",
                   m_struct_axis_tdata);
        end else begin
          exp_word = sb.pop_front();
          if (m_struct_axis_tdata !== exp_word) begin
            errors++;
            $display("FAIL sb_data: got tdata=%h, required %h", m_struct_axis_tdata, exp_word);
          end else if (verbose) begin
            $display("out  tdata=%h @%0t", m_struct_axis_tdata, $time);
          end
        end
      end
      if (s_struct_axis_tvalid && s_struct_axis_tready && s_val_axis_tvalid && s_val_axis_tready) begin
        sb.push_back(model(s_struct_axis_tdata, s_val_axis_tdata));
        if (verbose) $display("join struct=%h val=%h @%0t", s_struct_axis_tdata, s_val_axis_tdata, $time);
      end
      hold_prev = m_struct_axis_tvalid && !m_struct_axis_tready;
      prev_data = m_struct_axis_tdata;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic test_reset;
    s_struct_axis_tvalid = 1'b1;
    s_val_axis_tvalid    = 1'b1;
    m_struct_axis_tready = 1'b1;
    step;
    step;
    @(negedge clk);
    checks++;
    if (m_struct_axis_tvalid !== 1'b0 || s_struct_axis_tready !== 1'b0 || s_val_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: tvalid=%b s_tready=%b v_tready=%b, required 0 0 0",
               m_struct_axis_tvalid, s_struct_axis_tready, s_val_axis_tready);
    end
    step;
    s_struct_axis_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (s_struct_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_early: s_tready=%b, required 0", s_struct_axis_tready);
    end
    step;
    @(negedge clk);
    checks++;
    if (s_struct_axis_tready !== 1'b1 || m_struct_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_rdy: s_tready=%b tvalid=%b, required 1 0",
               s_struct_axis_tready, m_struct_axis_tvalid);
    end
    step;
    s_val_axis_tvalid = 1'b0;
  endtask

  task automatic test_single;
    m_struct_axis_tready = 1'b1;
    s_struct_axis_tdata  = 16'hABCD;
    s_val_axis_tdata     = 4'h5;
    s_struct_axis_tvalid = 1'b1;
    s_val_axis_tvalid    = 1'b1;
    step;
    s_struct_axis_tvalid = 1'b0;
    s_val_axis_tvalid    = 1'b0;
    @(negedge clk);
    checks++;
    if (m_struct_axis_tvalid !== 1'b1 || m_struct_axis_tdata !== 16'hAB5D) begin
      errors++;
      $display("FAIL single_out: tvalid=%b tdata=%h, required 1 AB5D",
               m_struct_axis_tvalid, m_struct_axis_tdata);
    end
    step;
    @(negedge clk);
    checks++;
    if (m_struct_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_once: tvalid=%b, required 0", m_struct_axis_tvalid);
    end
    step;
  endtask

  task automatic test_wait_val;
    m_struct_axis_tready = 1'b1;
    s_struct_axis_tdata  = 16'hABCD;
    s_struct_axis_tvalid = 1'b1;
    s_val_axis_tvalid    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (s_struct_axis_tready !== 1'b0 || m_struct_axis_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL wait_val_idle: cycle %0d s_tready=%b tvalid=%b, required 0 0",
                 i, s_struct_axis_tready, m_struct_axis_tvalid);
      end
      step;
    end
    s_val_axis_tdata  = 4'h0;
    s_val_axis_tvalid = 1'b1;
    step;
    s_struct_axis_tvalid = 1'b0;
    s_val_axis_tvalid    = 1'b0;
    @(negedge clk);
    checks++;
    if (m_struct_axis_tvalid !== 1'b1 || m_struct_axis_tdata !== 16'hAB0D) begin
      errors++;
      $display("FAIL wait_val_out: tvalid=%b tdata=%h, required 1 AB0D",
               m_struct_axis_tvalid, m_struct_axis_tdata);
    end
    step;
    @(negedge clk);
    checks++;
    if (m_struct_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL wait_val_once: tvalid=%b, required 0", m_struct_axis_tvalid);
    end
    step;
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_word;
    m_struct_axis_tready = 1'b1;
    s_val_axis_tdata     = 4'hF;
    s_struct_axis_tvalid = 1'b1;
    s_val_axis_tvalid    = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) s_struct_axis_tdata = 16'(i);
      else begin
        s_struct_axis_tvalid = 1'b0;
        s_val_axis_tvalid    = 1'b0;
      end
      @(negedge clk);
      if (i > 0) begin
        exp_word = 16'h00F0 + 16'(i - 1);
        checks++;
        if (m_struct_axis_tvalid !== 1'b1 || m_struct_axis_tdata !== exp_word) begin
          errors++;
          $display("FAIL b2b_out: word %0d tvalid=%b tdata=%h, required 1 %h",
                   i - 1, m_struct_axis_tvalid, m_struct_axis_tdata, exp_word);
        end
      end
      if (i < 10) begin
        checks++;
        if (s_struct_axis_tready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready: word %0d s_tready=%b, required 1", i, s_struct_axis_tready);
        end
      end
      step;
    end
  endtask

  task automatic test_backpressure;
    int acc = 0;
    m_struct_axis_tready = 1'b0;
    s_struct_axis_tvalid = 1'b1;
    s_val_axis_tvalid    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      s_struct_axis_tdata = 16'h5A00 + 16'(acc);
      s_val_axis_tdata    = 4'(acc + 1);
      @(negedge clk);
      if (s_struct_axis_tready && s_val_axis_tready) acc++;
      step;
    end
    s_struct_axis_tdata = 16'h5A00 + 16'(acc);
    s_val_axis_tdata    = 4'(acc + 1);
    @(negedge clk);
    checks++;
    if (acc != 2 || s_struct_axis_tready !== 1'b0 || s_val_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: joins=%0d s_tready=%b v_tready=%b, required 2 0 0",
               acc, s_struct_axis_tready, s_val_axis_tready);
    end
    checks++;
    if (m_struct_axis_tvalid !== 1'b1 || m_struct_axis_tdata !== 16'h5A10) begin
      errors++;
      $display("FAIL bp_frozen: tvalid=%b tdata=%h, required 1 5A10",
               m_struct_axis_tvalid, m_struct_axis_tdata);
    end
    step;
    m_struct_axis_tready = 1'b1;
    @(negedge clk);
    checks++;
    if (m_struct_axis_tdata !== 16'h5A10) begin
      errors++;
      $display("FAIL bp_drain0: tdata=%h, required 5A10", m_struct_axis_tdata);
    end
    step;
    @(negedge clk);
    checks++;
    if (m_struct_axis_tvalid !== 1'b1 || m_struct_axis_tdata !== 16'h5A21 || s_struct_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain1: tvalid=%b tdata=%h s_tready=%b, required 1 5A21 1",
               m_struct_axis_tvalid, m_struct_axis_tdata, s_struct_axis_tready);
    end
    step;
    s_struct_axis_tvalid = 1'b0;
    s_val_axis_tvalid    = 1'b0;
    repeat (3) step;
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || m_struct_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: pending=%0d tvalid=%b, required 0 0", sb.size(), m_struct_axis_tvalid);
    end
    step;
  endtask

  task automatic test_reset_full;
    int j = 0;
    m_struct_axis_tready = 1'b0;
    s_struct_axis_tdata  = 16'h1111;
    s_val_axis_tdata     = 4'h2;
    s_struct_axis_tvalid = 1'b1;
    s_val_axis_tvalid    = 1'b1;
    repeat (3) step;
    @(negedge clk);
    checks++;
    if (s_struct_axis_tready !== 1'b0 || m_struct_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL rstfull_pre: s_tready=%b tvalid=%b, required 0 1",
               s_struct_axis_tready, m_struct_axis_tvalid);
    end
    step;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (m_struct_axis_tvalid !== 1'b0 || s_struct_axis_tready !== 1'b0 || s_val_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL rstfull_async: tvalid=%b s_tready=%b v_tready=%b, required 0 0 0",
               m_struct_axis_tvalid, s_struct_axis_tready, s_val_axis_tready);
    end
    sb.delete();
    s_struct_axis_tvalid = 1'b0;
    s_val_axis_tvalid    = 1'b0;
    repeat (2) step;
    rst = 1'b1;
    m_struct_axis_tready = 1'b1;
    s_struct_axis_tdata  = 16'h1357;
    s_val_axis_tdata     = 4'h9;
    s_struct_axis_tvalid = 1'b1;
    s_val_axis_tvalid    = 1'b1;
    @(negedge clk);
    while (!s_struct_axis_tready && j < 10) begin
      step;
      @(negedge clk);
      j++;
    end
    checks++;
    if (j >= 10) begin
      errors++;
      $display("FAIL rstfull_timeout: s_tready=%b after %0d cycles, required 1", s_struct_axis_tready, j);
    end
    step;
    s_struct_axis_tdata = 16'h2468;
    s_val_axis_tdata    = 4'h1;
    @(negedge clk);
    checks++;
    if (m_struct_axis_tvalid !== 1'b1 || m_struct_axis_tdata !== 16'h1397) begin
      errors++;
      $display("FAIL rstfull_first: tvalid=%b tdata=%h, required 1 1397",
               m_struct_axis_tvalid, m_struct_axis_tdata);
    end
    step;
    s_struct_axis_tvalid = 1'b0;
    s_val_axis_tvalid    = 1'b0;
    repeat (3) step;
  endtask

  task automatic test_random;
    int   sent = 0;
    int   cyc = 0;
    int   start_out;
    int   k = 0;
    logic took;
    verbose   = 1'b0;
    start_out = n_out;
    s_struct_axis_tvalid = 1'b0;
    s_val_axis_tvalid    = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      @(negedge clk);
      took = s_struct_axis_tvalid && s_struct_axis_tready && s_val_axis_tvalid && s_val_axis_tready;
      if (took) sent++;
      step;
      cyc++;
      if (took || !s_struct_axis_tvalid) begin
        s_struct_axis_tvalid = ($urandom_range(0, 3) != 0);
        s_struct_axis_tdata  = 16'($urandom);
      end
      if (took || !s_val_axis_tvalid) begin
        s_val_axis_tvalid = ($urandom_range(0, 3) != 0);
        s_val_axis_tdata  = 4'($urandom);
      end
      m_struct_axis_tready = ($urandom_range(0, 2) != 0);
    end
    s_struct_axis_tvalid = 1'b0;
    s_val_axis_tvalid    = 1'b0;
    m_struct_axis_tready = 1'b1;
    checks++;
    if (sent != 10000) begin
      errors++;
      $display("FAIL rand_timeout: joined %0d words in %0d cycles, required 10000", sent, cyc);
    end
    while ((sb.size() != 0 || m_struct_axis_tvalid) && k < 20) begin
      step;
      k++;
    end
    @(negedge clk);
    checks++;
    if (n_out - start_out != 10000 || sb.size() != 0) begin
      errors++;
      $display("FAIL rand_count: outputs=%0d pending=%0d, required 10000 0", n_out - start_out, sb.size());
    end
    $display("random: %0d words joined in %0d cycles", sent, cyc);
  endtask

  initial begin
    test_reset;
    test_single;
    test_wait_val;
    test_back_to_back;
    test_backpressure;
    test_reset_full;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, required completion before 900000");
    $fatal(1, "watchdog expired");
  end

endmodule
